// File: rtl/lc3_uart_mmio.sv
// LC-3 memory-mapped UART: KBSR/KBDR/DSR/DDR over TX and RX FIFOs.
// Define LC3_UART_IRQ_EN for bit-14 interrupt enables and o_Irq.
module lc3_uart_mmio #(
  parameter int CLKS_PER_BIT = 87,
  parameter int TX_DEPTH     = 4,
  parameter int RX_DEPTH     = 4
) (
  input  logic        i_Clk,
  input  logic        i_Rst,
  input  logic [15:0] i_Addr,
  input  logic        i_Wr_En,
  input  logic        i_Rd_En,
  input  logic [15:0] i_Wdata,
  output logic [15:0] o_Rdata,
  output logic        o_Hit,
  input  logic        i_Rx_Serial,
`ifdef LC3_UART_IRQ_EN
  output logic        o_Irq,
`endif
  output logic        o_Tx_Serial
);

  localparam int TAW = $clog2(TX_DEPTH);
  localparam int RAW = $clog2(RX_DEPTH);
  localparam int CW  = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] C_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] C_HALF = CW'(CLKS_PER_BIT / 2 - 1);

  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_st_t;
  typedef enum logic [2:0] {
    RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_WAIT
  } rx_st_t;

  logic hit_kbsr, hit_kbdr, hit_dsr, hit_ddr;
  assign hit_kbsr = (i_Addr == 16'hFE00);
  assign hit_kbdr = (i_Addr == 16'hFE02);
  assign hit_dsr  = (i_Addr == 16'hFE04);
  assign hit_ddr  = (i_Addr == 16'hFE06);
  assign o_Hit    = hit_kbsr | hit_kbdr | hit_dsr | hit_ddr;

  logic unused_ok;
  assign unused_ok = ^i_Wdata[15:8];

  // TX FIFO
  logic [7:0]   tx_mem [TX_DEPTH];
  logic [TAW:0] tx_wp, tx_rp;
  logic         tx_empty, tx_full, tx_push, tx_pop;
  logic [7:0]   tx_head, ddr_last;
  assign tx_empty = (tx_wp == tx_rp);
  assign tx_full  = (tx_wp[TAW] != tx_rp[TAW]) &&
                    (tx_wp[TAW-1:0] == tx_rp[TAW-1:0]);
  assign tx_head  = tx_mem[tx_rp[TAW-1:0]];
  assign tx_push  = i_Wr_En && hit_ddr && (!tx_full || tx_pop);

  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      tx_wp    <= '0;
      tx_rp    <= '0;
      ddr_last <= '0;
    end else begin
      if (tx_push) tx_wp <= tx_wp + (TAW+1)'(1);
      if (tx_pop) tx_rp <= tx_rp + (TAW+1)'(1);
      if (i_Wr_En && hit_ddr) ddr_last <= i_Wdata[7:0];
    end
  end

  always_ff @(posedge i_Clk) begin
    if (tx_push) tx_mem[tx_wp[TAW-1:0]] <= i_Wdata[7:0];
  end

  // TX FSM
  tx_st_t        tx_st, tx_st_n;
  logic [CW-1:0] tx_cnt, tx_cnt_n;
  logic [2:0]    tx_bit, tx_bit_n;
  logic [7:0]    tx_sh, tx_sh_n;
  logic          tx_line_n;

  always_comb begin
    tx_st_n  = tx_st;
    tx_cnt_n = tx_cnt;
    tx_bit_n = tx_bit;
    tx_sh_n  = tx_sh;
    tx_pop   = 1'b0;
    unique case (tx_st)
      TX_IDLE: if (!tx_empty) begin
        tx_pop   = 1'b1;
        tx_sh_n  = tx_head;
        tx_cnt_n = '0;
        tx_st_n  = TX_START;
      end
      TX_START: if (tx_cnt == C_LAST) begin
        tx_cnt_n = '0;
        tx_bit_n = '0;
        tx_st_n  = TX_DATA;
      end else tx_cnt_n = tx_cnt + CW'(1);
      TX_DATA: if (tx_cnt == C_LAST) begin
        tx_cnt_n = '0;
        tx_sh_n  = {1'b0, tx_sh[7:1]};
        if (tx_bit == 3'd7) tx_st_n = TX_STOP;
        else tx_bit_n = tx_bit + 3'd1;
      end else tx_cnt_n = tx_cnt + CW'(1);
      TX_STOP: if (tx_cnt == C_LAST) begin
        tx_cnt_n = '0;
        // chain straight into the next frame when one is queued
        if (!tx_empty) begin
          tx_pop  = 1'b1;
          tx_sh_n = tx_head;
          tx_st_n = TX_START;
        end else tx_st_n = TX_IDLE;
      end else tx_cnt_n = tx_cnt + CW'(1);
      default: tx_st_n = TX_IDLE;
    endcase
    tx_line_n = (tx_st == TX_START) ? 1'b0 :
                (tx_st == TX_DATA)  ? tx_sh[0] : 1'b1;
  end

  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      tx_st       <= TX_IDLE;
      tx_cnt      <= '0;
      tx_bit      <= '0;
      tx_sh       <= '0;
      o_Tx_Serial <= 1'b1;
    end else begin
      tx_st       <= tx_st_n;
      tx_cnt      <= tx_cnt_n;
      tx_bit      <= tx_bit_n;
      tx_sh       <= tx_sh_n;
      o_Tx_Serial <= tx_line_n;
    end
  end

  // RX synchronizer and FSM
  logic          rx_s1, rx_s2;
  rx_st_t        rx_st, rx_st_n;
  logic [CW-1:0] rx_cnt, rx_cnt_n;
  logic [2:0]    rx_bit, rx_bit_n;
  logic [7:0]    rx_sh, rx_sh_n;
  logic          rx_done, ferr_set;

  always_comb begin
    rx_st_n  = rx_st;
    rx_cnt_n = rx_cnt;
    rx_bit_n = rx_bit;
    rx_sh_n  = rx_sh;
    rx_done  = 1'b0;
    ferr_set = 1'b0;
    unique case (rx_st)
      RX_IDLE: if (!rx_s2) begin
        rx_cnt_n = '0;
        rx_st_n  = RX_START;
      end
      RX_START: if (rx_cnt == C_HALF) begin
        rx_cnt_n = '0;
        rx_bit_n = '0;
        rx_st_n  = rx_s2 ? RX_IDLE : RX_DATA;
      end else rx_cnt_n = rx_cnt + CW'(1);
      RX_DATA: if (rx_cnt == C_LAST) begin
        rx_cnt_n = '0;
        rx_sh_n  = {rx_s2, rx_sh[7:1]};
        if (rx_bit == 3'd7) rx_st_n = RX_STOP;
        else rx_bit_n = rx_bit + 3'd1;
      end else rx_cnt_n = rx_cnt + CW'(1);
      RX_STOP: if (rx_cnt == C_LAST) begin
        rx_cnt_n = '0;
        rx_done  = rx_s2;
        ferr_set = !rx_s2;
        rx_st_n  = rx_s2 ? RX_IDLE : RX_WAIT;
      end else rx_cnt_n = rx_cnt + CW'(1);
      RX_WAIT: if (rx_s2) rx_st_n = RX_IDLE;
      default: rx_st_n = RX_IDLE;
    endcase
  end

  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      rx_s1  <= 1'b1;
      rx_s2  <= 1'b1;
      rx_st  <= RX_IDLE;
      rx_cnt <= '0;
      rx_bit <= '0;
      rx_sh  <= '0;
    end else begin
      rx_s1  <= i_Rx_Serial;
      rx_s2  <= rx_s1;
      rx_st  <= rx_st_n;
      rx_cnt <= rx_cnt_n;
      rx_bit <= rx_bit_n;
      rx_sh  <= rx_sh_n;
    end
  end

  // RX FIFO and sticky status
  logic [7:0]   rx_mem [RX_DEPTH];
  logic [RAW:0] rx_wp, rx_rp;
  logic         rx_empty, rx_full, rx_pop, rx_wr, ovr_set;
  logic         ferr, ovr;
  logic [7:0]   rx_head;
  assign rx_empty = (rx_wp == rx_rp);
  assign rx_full  = (rx_wp[RAW] != rx_rp[RAW]) &&
                    (rx_wp[RAW-1:0] == rx_rp[RAW-1:0]);
  assign rx_head  = rx_empty ? 8'h00 : rx_mem[rx_rp[RAW-1:0]];
  assign rx_pop   = i_Rd_En && hit_kbdr && !rx_empty;
  assign rx_wr    = rx_done && (!rx_full || rx_pop);
  assign ovr_set  = rx_done && rx_full && !rx_pop;

  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      rx_wp <= '0;
      rx_rp <= '0;
      ferr  <= 1'b0;
      ovr   <= 1'b0;
    end else begin
      if (rx_wr) rx_wp <= rx_wp + (RAW+1)'(1);
      if (rx_pop) rx_rp <= rx_rp + (RAW+1)'(1);
      if (i_Rd_En && hit_kbsr) begin
        ferr <= 1'b0;
        ovr  <= 1'b0;
      end
      if (ferr_set) ferr <= 1'b1;
      if (ovr_set) ovr <= 1'b1;
    end
  end

  always_ff @(posedge i_Clk) begin
    if (rx_wr) rx_mem[rx_wp[RAW-1:0]] <= rx_sh;
  end

  logic ie_kb, ie_ds;
`ifdef LC3_UART_IRQ_EN
  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      ie_kb <= 1'b0;
      ie_ds <= 1'b0;
      o_Irq <= 1'b0;
    end else begin
      if (i_Wr_En && hit_kbsr) ie_kb <= i_Wdata[14];
      if (i_Wr_En && hit_dsr) ie_ds <= i_Wdata[14];
      o_Irq <= (!rx_empty && ie_kb) || (!tx_full && ie_ds);
    end
  end
`else
  assign ie_kb = 1'b0;
  assign ie_ds = 1'b0;
`endif

  logic tx_busy;
  assign tx_busy = (tx_st != TX_IDLE) || !tx_empty;

  always_comb begin
    o_Rdata = 16'h0000;
    unique case (1'b1)
      hit_kbsr: o_Rdata = {!rx_empty, ie_kb, 12'h000, ferr, ovr};
      hit_kbdr: o_Rdata = {8'h00, rx_head};
      hit_dsr:  o_Rdata = {!tx_full, ie_ds, 13'h0000, tx_busy};
      hit_ddr:  o_Rdata = {8'h00, ddr_last};
      default:  o_Rdata = 16'h0000;
    endcase
  end

endmodule

// File: tb/tb_lc3_uart_mmio.sv
// Directed bench for lc3_uart_mmio at CLKS_PER_BIT=4, depth 4 FIFOs.
// Bus and serial stimulus change 1 ns after each rising edge.
module tb_lc3_uart_mmio;

  logic        i_Clk = 1'b0;
  logic        i_Rst = 1'b1;
  logic [15:0] i_Addr = 16'h0000;
  logic        i_Wr_En = 1'b0;
  logic        i_Rd_En = 1'b0;
  logic [15:0] i_Wdata = 16'h0000;
  logic [15:0] o_Rdata;
  logic        o_Hit;
  logic        i_Rx_Serial = 1'b1;
  logic        o_Tx_Serial;

  int checks = 0;
  int failures = 0;

  lc3_uart_mmio #(
    .CLKS_PER_BIT(4),
    .TX_DEPTH(4),
    .RX_DEPTH(4)
  ) dut (
    .i_Clk(i_Clk),
    .i_Rst(i_Rst),
    .i_Addr(i_Addr),
    .i_Wr_En(i_Wr_En),
    .i_Rd_En(i_Rd_En),
    .i_Wdata(i_Wdata),
    .o_Rdata(o_Rdata),
    .o_Hit(o_Hit),
    .i_Rx_Serial(i_Rx_Serial),
    .o_Tx_Serial(o_Tx_Serial)
  );

  always #5 i_Clk = ~i_Clk;

  task automatic step();
    @(posedge i_Clk);
    #1;
  endtask

  task automatic peek(input logic [15:0] a, output logic [15:0] d);
    i_Addr = a;
    #1;
    d = o_Rdata;
  endtask

  task automatic bus_rd(input logic [15:0] a, output logic [15:0] d);
    i_Addr = a;
    i_Rd_En = 1'b1;
    #1;
    d = o_Rdata;
    step();
    i_Rd_En = 1'b0;
    i_Addr = 16'h0000;
  endtask

  task automatic bus_wr(input logic [15:0] a, input logic [15:0] d);
    i_Addr = a;
    i_Wdata = d;
    i_Wr_En = 1'b1;
    step();
    i_Wr_En = 1'b0;
    i_Addr = 16'h0000;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop);
    i_Rx_Serial = 1'b0;
    repeat (4) step();
    for (int i = 0; i < 8; i++) begin
      i_Rx_Serial = b[i];
      repeat (4) step();
    end
    i_Rx_Serial = stop;
    repeat (4) step();
    i_Rx_Serial = 1'b1;
  endtask

  task automatic test_reset();
    logic [15:0] d;
    i_Rst = 1'b1;
    repeat (2) step();
    i_Rst = 1'b0;
    checks++;
    if (o_Tx_Serial !== 1'b1) begin
      failures++;
      $display("FAIL rst_tx_line got=%b exp=1", o_Tx_Serial);
    end
    peek(16'hFE04, d);
    checks++;
    if (d !== 16'h8000 || o_Hit !== 1'b1) begin
      failures++;
      $display("FAIL rst_dsr got=%h hit=%b exp=8000 hit=1", d, o_Hit);
    end
    peek(16'hFE00, d);
    checks++;
    if (d !== 16'h0000) begin
      failures++;
      $display("FAIL rst_kbsr got=%h exp=0000", d);
    end
    peek(16'hFE02, d);
    checks++;
    if (d !== 16'h0000) begin
      failures++;
      $display("FAIL rst_kbdr got=%h exp=0000", d);
    end
    peek(16'hFE01, d);
    checks++;
    if (d !== 16'h0000 || o_Hit !== 1'b0) begin
      failures++;
      $display("FAIL nohit_fe01 got=%h hit=%b exp=0000 hit=0", d, o_Hit);
    end
    peek(16'h3000, d);
    checks++;
    if (d !== 16'h0000 || o_Hit !== 1'b0) begin
      failures++;
      $display("FAIL nohit_3000 got=%h hit=%b exp=0000 hit=0", d, o_Hit);
    end
    i_Addr = 16'h0000;
  endtask

  task automatic test_reg_writes();
    logic [15:0] d;
    bus_wr(16'hFE00, 16'hFFFF);
    bus_wr(16'hFE04, 16'hFFFF);
    bus_wr(16'hFE02, 16'hFFFF);
    peek(16'hFE00, d);
    checks++;
    if (d !== 16'h0000) begin
      failures++;
      $display("FAIL wr_kbsr_ignored got=%h exp=0000", d);
    end
    peek(16'hFE04, d);
    checks++;
    if (d !== 16'h8000) begin
      failures++;
      $display("FAIL wr_dsr_ignored got=%h exp=8000", d);
    end
    i_Addr = 16'h0000;
  endtask

  task automatic test_tx_single();
    logic [15:0] d;
    logic [9:0]  fv;
    logic        berr;
    int          bit_i;
    fv = {1'b1, 8'h41, 1'b0};
    bus_wr(16'hFE06, 16'h0041);
    checks++;
    if (o_Tx_Serial !== 1'b1) begin
      failures++;
      $display("FAIL tx_n0 got=%b exp=1", o_Tx_Serial);
    end
    step();
    checks++;
    if (o_Tx_Serial !== 1'b1) begin
      failures++;
      $display("FAIL tx_n1 got=%b exp=1", o_Tx_Serial);
    end
    step();
    berr = 1'b0;
    for (int k = 0; k < 40; k++) begin
      bit_i = k / 4;
      if (o_Tx_Serial !== fv[bit_i]) berr = 1'b1;
      if ((k % 4) == 3) begin
        checks++;
        if (berr) begin
          failures++;
          $display("FAIL tx_bit%0d got=%b exp=%b", bit_i, o_Tx_Serial,
                   fv[bit_i]);
        end
        berr = 1'b0;
      end
      if (k == 20 || k == 38 || k == 39) begin
        peek(16'hFE04, d);
        checks++;
        if (d !== ((k == 39) ? 16'h8000 : 16'h8001)) begin
          failures++;
          $display("FAIL tx_dsr_k%0d got=%h exp=%h", k, d,
                   (k == 39) ? 16'h8000 : 16'h8001);
        end
        i_Addr = 16'h0000;
      end
      step();
    end
    peek(16'hFE06, d);
    checks++;
    if (d !== 16'h0041) begin
      failures++;
      $display("FAIL tx_ddr_read got=%h exp=0041", d);
    end
    i_Addr = 16'h0000;
  endtask

  task automatic test_back_to_back();
    logic [7:0]  bytes [6];
    logic [9:0]  fv;
    logic [15:0] d;
    logic        ferr [7];
    logic        exp_l;
    int          idx, f;
    bytes = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h07};
    for (int i = 0; i < 7; i++) ferr[i] = 1'b0;
    i_Addr = 16'hFE06;
    i_Wdata = 16'h0001;
    i_Wr_En = 1'b1;
    for (int t = 1; t <= 250; t++) begin
      step();
      if (t < 3) exp_l = 1'b1;
      else begin
        idx = t - 3;
        f = idx / 40;
        if (f < 6) begin
          fv = {1'b1, bytes[f], 1'b0};
          exp_l = fv[(idx % 40) / 4];
        end else exp_l = 1'b1;
      end
      if (o_Tx_Serial !== exp_l) begin
        if (t < 3) ferr[6] = 1'b1;
        else ferr[(f < 6) ? f : 6] = 1'b1;
      end
      if (t + 1 <= 6) begin
        i_Wdata = 16'(t + 1);
      end else if (t + 1 == 42) begin
        i_Addr = 16'hFE06;
        i_Wdata = 16'h0007;
        i_Wr_En = 1'b1;
      end else begin
        i_Wr_En = 1'b0;
        i_Addr = 16'h0000;
      end
      if (t == 6 || t == 42) begin
        peek(16'hFE04, d);
        checks++;
        if (d !== 16'h0001) begin
          failures++;
          $display("FAIL b2b_dsr_full_t%0d got=%h exp=0001", t, d);
        end
        i_Addr = 16'h0000;
      end
    end
    for (int i = 0; i < 7; i++) begin
      checks++;
      if (ferr[i]) begin
        failures++;
        $display("FAIL b2b_frame%0d got=wrong_line exp=%h", i,
                 (i < 6) ? bytes[i] : 8'hFF);
      end
    end
    peek(16'hFE04, d);
    checks++;
    if (d !== 16'h8000) begin
      failures++;
      $display("FAIL b2b_dsr_idle got=%h exp=8000", d);
    end
    i_Addr = 16'h0000;
  endtask

  task automatic test_rx_single();
    logic [15:0] d;
    send_frame(8'h5A, 1'b1);
    repeat (4) step();
    bus_rd(16'hFE00, d);
    checks++;
    if (d !== 16'h8000) begin
      failures++;
      $display("FAIL rx_kbsr got=%h exp=8000", d);
    end
    bus_rd(16'hFE02, d);
    checks++;
    if (d !== 16'h005A) begin
      failures++;
      $display("FAIL rx_kbdr got=%h exp=005a", d);
    end
    bus_rd(16'hFE00, d);
    checks++;
    if (d !== 16'h0000) begin
      failures++;
      $display("FAIL rx_kbsr_after got=%h exp=0000", d);
    end
  endtask

  task automatic test_rx_overrun();
    logic [15:0] d;
    logic [7:0]  bytes [5];
    bytes = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
    for (int i = 0; i < 5; i++) send_frame(bytes[i], 1'b1);
    repeat (4) step();
    bus_rd(16'hFE00, d);
    checks++;
    if (d !== 16'h8001) begin
      failures++;
      $display("FAIL ovr_kbsr got=%h exp=8001", d);
    end
    bus_rd(16'hFE00, d);
    checks++;
    if (d !== 16'h8000) begin
      failures++;
      $display("FAIL ovr_kbsr_clr got=%h exp=8000", d);
    end
    for (int i = 0; i < 4; i++) begin
      bus_rd(16'hFE02, d);
      checks++;
      if (d !== {8'h00, bytes[i]}) begin
        failures++;
        $display("FAIL ovr_kbdr%0d got=%h exp=%h", i, d, {8'h00, bytes[i]});
      end
    end
    bus_rd(16'hFE02, d);
    checks++;
    if (d !== 16'h0000) begin
      failures++;
      $display("FAIL ovr_kbdr_empty got=%h exp=0000", d);
    end
    bus_rd(16'hFE00, d);
    checks++;
    if (d !== 16'h0000) begin
      failures++;
      $display("FAIL ovr_kbsr_empty got=%h exp=0000", d);
    end
  endtask

  task automatic test_rx_errors();
    logic [15:0] d;
    send_frame(8'h33, 1'b0);
    repeat (6) step();
    bus_rd(16'hFE00, d);
    checks++;
    if (d !== 16'h0002) begin
      failures++;
      $display("FAIL ferr_kbsr got=%h exp=0002", d);
    end
    bus_rd(16'hFE00, d);
    checks++;
    if (d !== 16'h0000) begin
      failures++;
      $display("FAIL ferr_clr got=%h exp=0000", d);
    end
    i_Rx_Serial = 1'b0;
    step();
    i_Rx_Serial = 1'b1;
    repeat (20) step();
    bus_rd(16'hFE00, d);
    checks++;
    if (d !== 16'h0000) begin
      failures++;
      $display("FAIL glitch_kbsr got=%h exp=0000", d);
    end
    send_frame(8'hA5, 1'b1);
    repeat (4) step();
    bus_rd(16'hFE02, d);
    checks++;
    if (d !== 16'h00A5) begin
      failures++;
      $display("FAIL post_glitch_kbdr got=%h exp=00a5", d);
    end
  endtask

  task automatic test_reset_mid_tx();
    logic [15:0] d;
    logic        bad;
    bus_wr(16'hFE06, 16'h0000);
    repeat (10) step();
    checks++;
    if (o_Tx_Serial !== 1'b0) begin
      failures++;
      $display("FAIL midtx_low got=%b exp=0", o_Tx_Serial);
    end
    i_Rst = 1'b1;
    step();
    checks++;
    if (o_Tx_Serial !== 1'b1) begin
      failures++;
      $display("FAIL midtx_rst_line got=%b exp=1", o_Tx_Serial);
    end
    i_Rst = 1'b0;
    peek(16'hFE04, d);
    checks++;
    if (d !== 16'h8000) begin
      failures++;
      $display("FAIL midtx_dsr got=%h exp=8000", d);
    end
    i_Addr = 16'h0000;
    bad = 1'b0;
    for (int k = 0; k < 50; k++) begin
      step();
      if (o_Tx_Serial !== 1'b1) bad = 1'b1;
    end
    checks++;
    if (bad) begin
      failures++;
      $display("FAIL midtx_stays_idle got=0 exp=1");
    end
  endtask

  initial begin
    test_reset();
    test_reg_writes();
    test_tx_single();
    test_back_to_back();
    test_rx_single();
    test_rx_overrun();
    test_rx_errors();
    test_reset_mid_tx();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
